// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder walks the operands LSB first
// and publishes {cout, sum} once every bit has been consumed.
//
//   state  | meaning
//   IDLE   | waiting for start; operands, carry-in and counter load on accept
//   RUN    | one bit per cycle through the full adder; busy high
//   DONE   | result published; done high for exactly one cycle
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic fa_s;
   logic fa_co;

   // The single full adder shared by every bit position.
   always_comb begin
      fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
      fa_co = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            a_sr_d              = a_sr_q >> 1;
            b_sr_d              = b_sr_q >> 1;
            psum_d              = psum_q >> 1;
            psum_d[WIDTH-1]     = fa_s;
            carry_d             = fa_co;
            if (cnt_q == LAST_BIT) begin
               // Hold the counter on the final bit so it never wraps mid-transaction.
               sum_d   = psum_d;
               cout_d  = fa_co;
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q + CW'(1);
               busy_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
